// File: rtl/apb_master_bridge.sv
// APB4 initiator: turns single valid/ready requests into SETUP/ACCESS transfers with a one-cycle response strobe.
// Optional macro APB_TIMEOUT_EN adds an ACCESS wait-state timeout of TIMEOUT_CYCLES.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 1023)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..1023");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

`ifdef APB_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;
  logic       timeout_hit;

  // Reached on the ACCESS cycle that brings the stall count up to TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == 10'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr & ~ADDR_WIDTH'(3);
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          state_d = ST_RESP;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 10'd1;
          if (timeout_hit) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (PRESET) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign PSEL       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE    = (state_q == ST_ACCESS);
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  // Response fields are gated so they read as zero outside the response cycle.
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a response scoreboard plus cycle-level protocol checks.
module tb_apb_master_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Every response strobe must match the oldest outstanding expectation.
  always @(negedge PCLK) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", resp_valid, 0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("sb_rdata", resp_rdata, e.rdata);
        check("sb_err", resp_err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // One transfer: `waits` ACCESS cycles with PREADY low, then PREADY high.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int waits, input logic [DW-1:0] rdata,
                          input logic err);
    int            lat;
    int            acc;
    resp_t         e;
    logic [AW-1:0] exp_addr;
    exp_addr = addr & 16'hFFFC;
    lat = 1;
    acc = 0;
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    PREADY = 1'b0; PRDATA = rdata; PSLVERR = ~err;
    e.rdata = wr ? '0 : rdata;
    e.err   = err;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, exp_addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_pstrb", PSTRB, wr ? strb : 4'h0);
    check("setup_resp_rdata_zero", resp_rdata, 0);
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (PSEL && PENABLE) begin
        acc++;
        check("access_paddr_hold", PADDR, exp_addr);
        PREADY  = (acc > waits);
        PSLVERR = (acc > waits) ? err : ~err;
      end
      tick();
      lat++;
    end
    check("resp_seen", resp_valid, 1);
    check("access_cycles", acc, 1 + waits);
    check("resp_latency", lat, 3 + waits);
    check("resp_psel_low", PSEL, 0);
    check("resp_req_ready_low", req_ready, 0);
    PREADY = 1'b0;
    tick();
    check("back_to_idle", req_ready, 1);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic run_timeout();
    int    lat;
    int    acc;
    resp_t e;
    lat = 1;
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h6004;
    PREADY = 1'b0; PRDATA = 32'h99999999; PSLVERR = 1'b1;
    e.rdata = '0;
    e.err   = 1'b1;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      if (PSEL && PENABLE) acc++;
      tick();
      lat++;
    end
    check("to_resp_seen", resp_valid, 1);
    check("to_access_cycles", acc, TO);
    check("to_latency", lat, 2 + TO);
    check("to_psel_dropped", PSEL, 0);
    tick();
    check("to_back_to_idle", req_ready, 1);
  endtask
`endif

  initial begin
    int    setups;
    int    setup_cyc[2];
    resp_t e;

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b1; req_addr = 16'hFFFF;
    req_wdata = 32'hFFFFFFFF; req_strb = 4'hF;
    PREADY = 1'b1; PRDATA = 32'hFFFFFFFF; PSLVERR = 1'b1;
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    PRESET = 1'b0;
    tick();
    check("idle_ignores_pslverr", resp_err, 0);
    check("idle_ignores_prdata", resp_rdata, 0);

    run_xfer(1'b1, 16'h2004, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0);
    run_xfer(1'b0, 16'h0008, 32'h0, 4'hF, 3, 32'h12345678, 1'b0);
    run_xfer(1'b1, 16'h3007, 32'h0BADF00D, 4'h5, 0, 32'h00000001, 1'b1);
    run_xfer(1'b0, 16'h3008, 32'h0, 4'h0, 0, 32'h87654321, 1'b1);
    run_xfer(1'b0, 16'hA00C, 32'h0, 4'h0, 2, 32'h0F0F0F0F, 1'b1);

`ifdef APB_TIMEOUT_EN
    run_timeout();
    run_xfer(1'b0, 16'h6000, 32'h0, 4'h0, TO - 1, 32'h55AA55AA, 1'b0);
`endif

    // Reset during ACCESS abandons the read with no response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h5010; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_in_access", PENABLE, 1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    check("abort_psel", PSEL, 0);
    check("abort_penable", PENABLE, 0);
    check("abort_req_ready", req_ready, 1);
    check("abort_paddr_cleared", PADDR, 0);
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_resp", resp_valid, 0);
    end

    // Two queued requests with req_valid held high must serialize.
    setups = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1000; req_wdata = 32'h11112222; req_strb = 4'h3;
    PREADY = 1'b1; PRDATA = 32'hCAFEF00D; PSLVERR = 1'b0;
    e.rdata = '0;          e.err = 1'b0; sb.push_back(e);
    e.rdata = 32'hCAFEF00D; e.err = 1'b0; sb.push_back(e);
    tick();
    req_write = 1'b0; req_addr = 16'h4020; req_wdata = 32'h33334444; req_strb = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      if (PSEL && !PENABLE) begin
        if (setups < 2) setup_cyc[setups] = c;
        setups++;
        if (setups == 2) begin
          req_valid = 1'b0;
          check("b2b_paddr_b", PADDR, 16'h4020);
          check("b2b_pstrb_b", PSTRB, 0);
        end
      end
      check("b2b_ready_only_idle", req_ready, !(PSEL || resp_valid));
      tick();
    end
    req_valid = 1'b0;
    check("b2b_setup_count", setups, 2);
    check("b2b_setup_spacing", setup_cyc[1] - setup_cyc[0], 4);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator for the peripheral subsystem: accepts single read/write requests on a simple valid/ready request port and executes each as a complete APB4 transfer (SETUP then ACCESS, with wait states), returning read data and error status on a one-cycle response strobe. It produces the shared PSEL, PADDR, PENABLE, PWRITE, PWDATA and PSTRB. The subsystem's slave-select decoder consumes these, using PADDR[15:12] to pick UART0, WDOG, TIMER, SPI, UART1 or the dual timer. It also samples the muxed PRDATA, PREADY and PSLVERR back from the selected slave.

## Interface
- ADDR_WIDTH, 16: PADDR width; bits [15:12] select the slave in the decoder.
- DATA_WIDTH, 32: PWDATA/PRDATA width; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles with PREADY low. Range 1..1023. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  single clock; all logic on the rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request (IDLE only).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- resp_valid  out  1  one-cycle pulse: transfer complete.
- resp_rdata  out  DATA_WIDTH  read data; valid with resp_valid.
- resp_err  out  1  PSLVERR or timeout; valid with resp_valid.
- PSEL  out  1  to subsystem decoder.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_WIDTH  transfer address, with [1:0] forced to 0.
- PWRITE  out  1  transfer direction.
- PWDATA  out  DATA_WIDTH  write data.
- PSTRB  out  DATA_WIDTH/8  write strobes; all 0 for reads.
- PRDATA  in  DATA_WIDTH  muxed slave read data.
- PREADY  in  1  muxed slave ready.
- PSLVERR  in  1  muxed slave error.

## Operation
- FSM states:
  - IDLE: req_ready=1. A request is accepted when req_valid and req_ready are both high; the bridge registers address, data, strobes and direction, then moves to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. The state holds while PREADY=0. When PREADY=1, the bridge captures PRDATA (reads only; writes return 0) and PSLVERR, then moves to RESP.
  - RESP: PSEL=0, PENABLE=0, resp_valid=1 for exactly this cycle, req_ready=0. Next state is IDLE.
- PADDR, PWRITE, PWDATA and PSTRB are registered at acceptance and held stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE and RESP; they are not zeroed.
- resp_rdata and resp_err are driven only in RESP and are 0 in every other state.
- In IDLE, PSLVERR and PRDATA are ignored. In ACCESS, PSLVERR is sampled only in the cycle where PREADY=1.
- req_valid asserted outside IDLE has no effect. The requester must hold the request until req_ready is seen.
- No back-to-back transfers: IDLE always separates one transfer from the next.

## Timing
- Reset (PRESET high at a PCLK edge) puts the FSM in IDLE. All outputs are 0 except req_ready, which is 1. This includes PADDR, PWDATA, PSTRB, resp_rdata and the timeout counter.
- Reset during SETUP or ACCESS: PSEL and PENABLE drop on the next edge, no resp_valid is produced, and the transfer is abandoned.
- Zero-wait transfer: accept at edge N. SETUP runs N+1, ACCESS N+2, RESP (resp_valid) N+3, IDLE N+4. Four cycles request to request.
- Each PREADY=0 cycle in ACCESS adds exactly one cycle of latency.
- PREADY=1 and PSLVERR=1 together in ACCESS give resp_err=1 in RESP, and read data is still captured.

## Configuration
- APB_TIMEOUT_EN defined:
  - A 10-bit counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the bridge goes to RESP with resp_err=1 and resp_rdata=0. PSEL and PENABLE drop that edge.
  - If PREADY=1 arrives in the same cycle the count reaches TIMEOUT_CYCLES, the transfer completes normally; PREADY wins.
- APB_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely for PREADY, and TIMEOUT_CYCLES is ignored.

## Test plan
- Write with req_addr=0x2004, req_wdata=0xDEADBEEF, req_strb=0xF, PREADY tied 1:
  - SETUP runs 1 cycle and ACCESS 1 cycle, with PADDR=0x2004, PWRITE=1, PWDATA=0xDEADBEEF.
  - resp_valid is high 3 cycles after acceptance, with resp_err=0.
- Read with req_addr=0x0008, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678:
  - ACCESS lasts 4 cycles, PSTRB=0.
  - resp_rdata=0x12345678 on resp_valid, 6 cycles after acceptance.
- Write with PSLVERR=1 and PREADY=1: resp_err=1. A read with the same stimulus gives resp_err=1 and resp_rdata equal to PRDATA.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, PREADY held 0:
  - After 4 ACCESS cycles the bridge goes to RESP with resp_err=1, resp_rdata=0, and returns to IDLE.
  - Repeat with PREADY=1 on the 4th cycle: normal completion.
- PRESET pulsed during ACCESS of a read: the next cycle shows PSEL=0, PENABLE=0, req_ready=1, and resp_valid is never asserted.
- req_valid held high continuously with two queued requests: transfers are serialized. req_ready is high only in IDLE, giving exactly one SETUP per accepted request.
